// File: rtl/x448_pkg.sv
// Shared X448 field constants and the responder FSM state encoding.
package x448_pkg;

    localparam int N_FIELD = 448;

    // p = 2^448 - 2^224 - 1
    localparam logic [N_FIELD-1:0] P448 = {{223{1'b1}}, 1'b0, {224{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mm_state_t;

endpackage

// File: rtl/mulmod_serial_if.sv
// req/res handshake bundle between an initiator (master) and mulmod_serial (slave).
interface mulmod_serial_if #(
    parameter int N = 448
);
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic [N-1:0] M;
    logic         req_valid;
    logic         req_ready;
    logic         req_busy;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] Z;

    modport master (
        output X, Y, M, req_valid, res_ready,
        input  req_ready, req_busy, res_valid, Z
    );

    modport slave (
        input  X, Y, M, req_valid, res_ready,
        output req_ready, req_busy, res_valid, Z
    );
endinterface

// File: rtl/mulmod_serial_addmod.sv
// Combinational modular adder: s = (a + b) mod m, for a, b < m.
module mulmod_serial_addmod #(
    parameter int N = 448
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] m,
    output logic [N-1:0] s
);
    logic [N:0] sum;

    // With a, b < m the sum is below 2m, so one subtraction always suffices.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, m}) begin
            s = N'(sum - {1'b0, m});
        end else begin
            s = sum[N-1:0];
        end
    end
endmodule

// File: rtl/mulmod_serial.sv
// Bit-serial interleaved modular multiplier Z = X*Y mod M, MSB-first, N cycles per product.
module mulmod_serial
    import x448_pkg::*;
#(
    parameter int N = N_FIELD
) (
    input  logic            clk,
    input  logic            rstn,
    mulmod_serial_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    mm_state_t     state;
    logic [N-1:0]  x_r;
    logic [N-1:0]  y_r;
    logic [N-1:0]  m_r;
    logic [N-1:0]  acc;
    logic [IW-1:0] i;
    logic          req_ready_r;
    logic          req_busy_r;
    logic          res_valid_r;

    logic [N-1:0]  dbl;
    logic [N-1:0]  sum;
    logic [N-1:0]  acc_next;

    mulmod_serial_addmod #(.N(N)) u_dbl (
        .a (acc),
        .b (acc),
        .m (m_r),
        .s (dbl)
    );

    mulmod_serial_addmod #(.N(N)) u_acc (
        .a (dbl),
        .b (y_r),
        .m (m_r),
        .s (sum)
    );

    always_comb begin
        acc_next = x_r[i] ? sum : dbl;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            x_r         <= '0;
            y_r         <= '0;
            m_r         <= '0;
            acc         <= '0;
            i           <= '0;
            req_ready_r <= 1'b1;
            req_busy_r  <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        x_r         <= bus.X;
                        y_r         <= bus.Y;
                        m_r         <= bus.M;
                        acc         <= '0;
                        i           <= IW'(N - 1);
                        req_ready_r <= 1'b0;
                        req_busy_r  <= 1'b1;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    if (i == '0) begin
                        req_busy_r  <= 1'b0;
                        res_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        i <= i - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.req_busy  = req_busy_r;
    assign bus.res_valid = res_valid_r;
    assign bus.Z         = acc;
endmodule
